vga_timing_gen: RTL

- Parametrised video timing generator that replaces the fixed divide-by-2 clock plus hvsync generator pairing.
- An internal pixel-enable divider drives the horizontal and vertical counters; all timing, sync polarity and divide ratio are parameters.
- Outputs: pixel position, display-enable, line/frame strobes, a frame counter, and a blanked RGB output.
- Sits between the board clock and any pixel-producing game/test logic.

---
 rtl/vga_timing_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator with pixel-enable divider
//
// Purpose: generates pixel position, syncs, display enable, line/frame strobes
// and a blanked colour output from the board clock. A clock-enable divider
// (CLK_DIV clk cycles per pixel) paces the horizontal/vertical counters.
//
// Ports:
//   clk         system clock
//   reset       synchronous active-low reset
//   en          run enable; low freezes divider and counters
//   rgb_in      pixel colour from the producer
//   hpos/vpos   current pixel column / line
//   display_on  current pixel lies in the visible area
//   pix_en      one-clk strobe on which the counters advance
//   line_start  one-clk pulse when hpos wraps to 0
//   frame_start one-clk pulse when hpos and vpos both wrap to 0
//   frame_cnt   completed-frame counter (wraps modulo 2^FRAME_W)
//   hsync/vsync sync outputs, active level H_POL/V_POL
//   rgb         rgb_in gated by display_on
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int CLK_DIV   = 2,
    parameter int RGB_W     = 3,
    parameter int FRAME_W   = 8,
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP,
    localparam int HW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int VW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [RGB_W-1:0]   rgb_in,
    output logic [HW-1:0]      hpos,
    output logic [VW-1:0]      vpos,
    output logic               display_on,
    output logic               pix_en,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               hsync,
    output logic               vsync,
    output logic [RGB_W-1:0]   rgb
);

    if (CLK_DIV < 1 || H_SYNC < 1 || V_SYNC < 1) begin : g_param_check
        $error("vga_timing_gen: CLK_DIV, H_SYNC and V_SYNC must all be >= 1");
    end

    localparam int             DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]  H_MAX   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_MAX   = VW'(V_TOTAL - 1);

    // Decode bounds kept at 32 bits: a sync end may equal the total and
    // would not fit in the counter width.
    localparam logic [31:0] H_VIS = 32'(H_DISPLAY);
    localparam logic [31:0] H_SS  = 32'(H_DISPLAY + H_FRONT);
    localparam logic [31:0] H_SE  = 32'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [31:0] V_VIS = 32'(V_DISPLAY);
    localparam logic [31:0] V_SS  = 32'(V_DISPLAY + V_BOTTOM);
    localparam logic [31:0] V_SE  = 32'(V_DISPLAY + V_BOTTOM + V_SYNC);

    logic [DW-1:0]      div_q,   div_d;
    logic [HW-1:0]      hpos_q,  hpos_d;
    logic [VW-1:0]      vpos_q,  vpos_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               disp_q,  disp_d;
    logic               hs_q,    hs_d;
    logic               vs_q,    vs_d;
    logic               ls_q,    ls_d;
    logic               fs_q,    fs_d;
    logic               pix_en_w;
    logic               h_wrap;
    logic               v_wrap;

    always_comb begin
        // Gated by reset so pix_en reads 0 while reset is held.
        pix_en_w = reset && en && (div_q == DIV_MAX);
        h_wrap   = (hpos_q == H_MAX);
        v_wrap   = (vpos_q == V_MAX);

        div_d   = div_q;
        hpos_d  = hpos_q;
        vpos_d  = vpos_q;
        frame_d = frame_q;

        if (en) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DW'(1);
        end

        if (pix_en_w) begin
            hpos_d = h_wrap ? '0 : hpos_q + HW'(1);
            if (h_wrap) begin
                vpos_d = v_wrap ? '0 : vpos_q + VW'(1);
                if (v_wrap) begin
                    frame_d = frame_q + FRAME_W'(1);
                end
            end
        end

        ls_d = pix_en_w && h_wrap;
        fs_d = ls_d && v_wrap;

        // Decodes use next-state position so they land on the same edge as it.
        disp_d = (32'(hpos_d) < H_VIS) && (32'(vpos_d) < V_VIS);
        hs_d   = (32'(hpos_d) >= H_SS && 32'(hpos_d) < H_SE) ? H_POL : ~H_POL;
        vs_d   = (32'(vpos_d) >= V_SS && 32'(vpos_d) < V_SE) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q   <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            frame_q <= '0;
            disp_q  <= 1'b1;
            hs_q    <= ~H_POL;
            vs_q    <= ~V_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            frame_q <= frame_d;
            disp_q  <= disp_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign display_on  = disp_q;
    assign pix_en      = pix_en_w;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = frame_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    // Combinational so the producer can answer hpos/vpos in the same cycle.
    assign rgb         = disp_q ? rgb_in : '0;

endmodule
